// File: rtl/cpu_types_pkg.sv
// Shared types for the fetch front end: machine word, fetch FSM states and
// the {instruction, PC+4} pair handed to decode.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    SQUASH = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

  localparam word_t PC_STEP = word_t'(4);

  typedef struct packed {
    word_t instr;
    word_t npc;
  } fetch_pair_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid register that parks a fetched {instr, npc} pair while the
// decode latch is stalled.
module fetch_skid_buf
  import cpu_types_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        clear_i,
  input  fetch_pair_t data_i,
  output logic        valid_o,
  output fetch_pair_t data_o
);

  logic        valid_q;
  fetch_pair_t data_q;

  // Clear wins over load so a redirect never leaves a stale entry behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues instruction reads and hands {instr, PC+4}
// to the decode latch, absorbing stalls, redirects and halt.
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic [31:0] instru,
  output logic [31:0] nPC,
  output logic        fvalid,
  input  logic        deen,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        flush
);

  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        sq_addr_q, sq_addr_d;
  word_t        pc_plus4;
  word_t        redir_pc;

  logic         buf_load, buf_clear, buf_valid;
  fetch_pair_t  buf_din, buf_dout;

  assign pc_plus4 = pc_q + PC_STEP;
  assign redir_pc = redirect_pc & ~word_t'(3);
  assign buf_din  = '{instr: imemload, npc: pc_plus4};

  fetch_skid_buf u_skid (
    .clk     (CLK),
    .rst     (RST),
    .load_i  (buf_load),
    .clear_i (buf_clear),
    .data_i  (buf_din),
    .valid_o (buf_valid),
    .data_o  (buf_dout)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= FETCH;
      pc_q      <= PC_INIT;
      sq_addr_q <= PC_INIT;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      sq_addr_q <= sq_addr_d;
    end
  end

  // Next state and outputs; everything stays quiet while RST is held.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    sq_addr_d = sq_addr_q;
    imemREN   = 1'b0;
    imemaddr  = pc_q;
    instru    = '0;
    nPC       = '0;
    fvalid    = 1'b0;
    flush     = 1'b0;
    buf_load  = 1'b0;
    buf_clear = 1'b0;

    if (!RST) begin
      unique case (state_q)
        FETCH: begin
          imemREN = 1'b1;
          if (halt) begin
            state_d = HALTED;
          end else if (redirect) begin
            flush     = 1'b1;
            buf_clear = 1'b1;
            pc_d      = redir_pc;
            // An outstanding read cannot be cancelled; wait it out in SQUASH.
            if (!ihit) begin
              sq_addr_d = pc_q;
              state_d   = SQUASH;
            end
          end else if (ihit) begin
            pc_d = pc_plus4;
            if (deen) begin
              fvalid = 1'b1;
              instru = imemload;
              nPC    = pc_plus4;
            end else begin
              buf_load = 1'b1;
              state_d  = HOLD;
            end
          end
        end

        HOLD: begin
          if (halt) begin
            state_d = HALTED;
          end else if (redirect) begin
            flush     = 1'b1;
            buf_clear = 1'b1;
            pc_d      = redir_pc;
            state_d   = FETCH;
          end else begin
            fvalid = buf_valid;
            instru = buf_dout.instr;
            nPC    = buf_dout.npc;
            if (deen) begin
              buf_clear = 1'b1;
              state_d   = FETCH;
            end
          end
        end

        SQUASH: begin
          imemREN  = 1'b1;
          imemaddr = sq_addr_q;
          if (halt) begin
            state_d = HALTED;
          end else if (redirect) begin
            flush = 1'b1;
            pc_d  = redir_pc;
          end else if (ihit) begin
            state_d = FETCH;
          end
        end

        HALTED: begin
        end

        default: state_d = FETCH;
      endcase
    end
  end

endmodule
